// File: rtl/driver_display_saida.sv
// Three-digit seven-segment driver for an 8-bit output register.
// A new OUT_BUS value is converted to BCD with an 8-step double dabble.
// The three digits are then scanned one-hot with leading-zero blanking.
module driver_display_saida #(
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [7:0] OUT_BUS,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  localparam logic [0:0]  IDLE     = 1'b0;
  localparam logic [0:0]  CONV     = 1'b1;
  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  logic [0:0]  state_reg;
  logic [7:0]  last_val_reg;
  logic [19:0] shift_reg;      // {hundreds, tens, units, binary}
  logic [2:0]  count_reg;
  logic [3:0]  hund_reg;
  logic [3:0]  tens_reg;
  logic [3:0]  units_reg;
  logic [15:0] div_reg;
  logic [1:0]  idx_reg;

  logic [19:0] adj;
  logic [19:0] shift_next;

  // One double-dabble step: bump each BCD nibble that is 5 or more by 3,
  // then shift the whole register left by one.
  assign adj[7:0] = shift_reg[7:0];
  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign adj[8+4*gi +: 4] = (shift_reg[8+4*gi +: 4] >= 4'd5) ?
                              shift_reg[8+4*gi +: 4] + 4'd3 :
                              shift_reg[8+4*gi +: 4];
  end
  assign shift_next = {adj[18:0], 1'b0};

  assign busy = (state_reg == CONV);

  // Conversion FSM; the displayed digits load only on the final step.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg    <= IDLE;
      last_val_reg <= 8'd0;
      shift_reg    <= 20'd0;
      count_reg    <= 3'd0;
      hund_reg     <= 4'd0;
      tens_reg     <= 4'd0;
      units_reg    <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (OUT_BUS != last_val_reg) begin
            last_val_reg <= OUT_BUS;
            shift_reg    <= {12'd0, OUT_BUS};
            count_reg    <= 3'd0;
            state_reg    <= CONV;
          end
        end
        default: begin
          shift_reg <= shift_next;
          count_reg <= count_reg + 3'd1;
          if (count_reg == 3'd7) begin
            hund_reg  <= shift_next[19:16];
            tens_reg  <= shift_next[15:12];
            units_reg <= shift_next[11:8];
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  // Scan divider: advance the digit index once every SCAN_DIV cycles.
  always_ff @(posedge clock) begin
    if (clear) begin
      div_reg <= 16'd0;
      idx_reg <= 2'd0;
    end else if (div_reg == DIV_LAST) begin
      div_reg <= 16'd0;
      idx_reg <= (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;
    end else begin
      div_reg <= div_reg + 16'd1;
    end
  end

  logic [3:0] digit;
  logic       blank;
  logic [6:0] seg_raw;

  // Digit select and leading-zero blanking, driven purely from registers.
  always_comb begin
    an    = 3'b001;
    digit = units_reg;
    blank = 1'b0;
    case (idx_reg)
      2'd1: begin
        an    = 3'b010;
        digit = tens_reg;
        blank = (hund_reg == 4'd0) && (tens_reg == 4'd0);
      end
      2'd2: begin
        an    = 3'b100;
        digit = hund_reg;
        blank = (hund_reg == 4'd0);
      end
      default: begin
        an    = 3'b001;
        digit = units_reg;
        blank = 1'b0;
      end
    endcase
  end

  // Seven-segment decode {a,b,c,d,e,f,g}, with optional polarity inversion.
  always_comb begin
    seg_raw = 7'h00;
    if (!blank) begin
      case (digit)
        4'd0:    seg_raw = 7'h7E;
        4'd1:    seg_raw = 7'h30;
        4'd2:    seg_raw = 7'h6D;
        4'd3:    seg_raw = 7'h79;
        4'd4:    seg_raw = 7'h33;
        4'd5:    seg_raw = 7'h5B;
        4'd6:    seg_raw = 7'h5F;
        4'd7:    seg_raw = 7'h70;
        4'd8:    seg_raw = 7'h7F;
        4'd9:    seg_raw = 7'h7B;
        default: seg_raw = 7'h00;
      endcase
    end
    seg = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
  end

endmodule

// File: tb/tb_driver_display_saida.sv
// Scoreboard bench for driver_display_saida (SCAN_DIV=4, active-high segments).
// Each value that should be converted is queued when driven; the monitor pops
// it when busy falls, checks the busy length and the scanned digits.
module tb_driver_display_saida;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic [7:0] OUT_BUS = 8'd0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];

  localparam logic [6:0] SEG_TBL [0:9] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                          7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  always #5 clock = ~clock;

  driver_display_saida #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clock   (clock),
    .clear   (clear),
    .OUT_BUS (OUT_BUS),
    .seg     (seg),
    .an      (an),
    .busy    (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected segments for digit position idx (0 units, 1 tens, 2 hundreds) of v.
  function automatic logic [6:0] exp_seg(input logic [7:0] v, input int idx);
    int h, t, u;
    h = int'(v) / 100;
    t = (int'(v) / 10) % 10;
    u = int'(v) % 10;
    case (idx)
      0:       return SEG_TBL[u];
      1:       return (h == 0 && t == 0) ? 7'h00 : SEG_TBL[t];
      default: return (h == 0) ? 7'h00 : SEG_TBL[h];
    endcase
  endfunction

  bit         mon_en    = 1'b0;
  bit         prev_busy = 1'b0;
  int         busy_len  = 0;
  int         win       = 0;
  logic [7:0] cur_val   = 8'd0;
  bit   [2:0] seen      = 3'b000;

  // Monitor: one-hot check every cycle; on busy falling, pop and check result.
  always @(negedge clock) begin
    if (mon_en) begin
      int idx;
      check_eq("an_onehot", 32'($onehot(an)), 32'd1);
      if (busy) busy_len++;
      if (prev_busy && !busy) begin
        check_eq("conv_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) cur_val = exp_q.pop_front();
        check_eq($sformatf("busy_len_v%0d", cur_val), busy_len, 8);
        busy_len = 0;
        seen     = 3'b000;
        win      = 9;
      end
      if (win > 0) begin
        idx = (an == 3'b010) ? 1 : (an == 3'b100) ? 2 : 0;
        if (!seen[idx]) begin
          seen[idx] = 1'b1;
          check_eq($sformatf("seg_d%0d_v%0d", idx, cur_val), 32'(seg), 32'(exp_seg(cur_val, idx)));
        end
        win--;
      end
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_val(input logic [7:0] v);
    OUT_BUS = v;
    exp_q.push_back(v);
  endtask

  initial begin
    // Reset for two cycles with OUT_BUS = 0.
    clear   = 1'b1;
    OUT_BUS = 8'd0;
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_an", 32'(an), 32'h1);
    check_eq("rst_seg", 32'(seg), 32'h7E);
    prev_busy = 1'b0;
    busy_len  = 0;
    mon_en    = 1'b1;

    // Idle scan: each digit enable held 4 cycles, display shows a lone 0.
    for (int k = 0; k < 13; k++) begin
      if (k > 0) tick();
      check_eq($sformatf("scan_an_k%0d", k), 32'(an), 32'(3'b001 << ((k / 4) % 3)));
      check_eq($sformatf("scan_seg_k%0d", k), 32'(seg), 32'(exp_seg(8'd0, (k / 4) % 3)));
    end
    check_eq("no_busy_after_rst", busy_len, 0);

    // 0 -> 255: busy rises right after the capture edge.
    drive_val(8'd255);
    check_eq("busy_pre_capture", 32'(busy), 32'd0);
    tick();
    check_eq("busy_after_capture", 32'(busy), 32'd1);
    repeat (20) tick();

    // 7: tens and hundreds blanked.
    drive_val(8'd7);
    repeat (20) tick();

    // 100 then 42 two cycles later; 42 arrives mid-conversion.
    drive_val(8'd100);
    tick();
    tick();
    drive_val(8'd42);
    repeat (30) tick();

    // Clear during the 4th conversion cycle of 200, then a fresh conversion.
    OUT_BUS = 8'd200;
    repeat (4) tick();
    mon_en = 1'b0;
    clear  = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("midconv_busy", 32'(busy), 32'd0);
    check_eq("midconv_an", 32'(an), 32'h1);
    check_eq("midconv_seg", 32'(seg), 32'h7E);
    exp_q.delete();
    exp_q.push_back(8'd200);
    prev_busy = 1'b0;
    busy_len  = 0;
    win       = 0;
    mon_en    = 1'b1;
    repeat (20) tick();

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
